// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with registered reads, write-first forwarding
// and a multi-cycle clear sequencer that zeroes the array without a global reset.
//   state   | meaning
//   S_IDLE  | normal operation; reads and writes accepted
//   S_CLEAR | one register zeroed per cycle; busy=1, reads and writes ignored
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  re0,
  input  logic [ADDR_WIDTH-1:0] rAddr0,
  output logic [DATA_WIDTH-1:0] rData0,
  output logic                  rValid0,
  input  logic                  re1,
  input  logic [ADDR_WIDTH-1:0] rAddr1,
  output logic [DATA_WIDTH-1:0] rData1,
  output logic                  rValid1,
  input  logic                  clr,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;
  logic                    rvalid0_q, rvalid1_q;
  logic [DATA_WIDTH-1:0]   rd_val0, rd_val1;
  logic                    accept;
  logic                    wr_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A clr request in IDLE takes priority over any access in the same cycle.
  assign accept = (state_q == S_IDLE) && !clr;
  assign wr_en  = accept && we && !((ZERO_REG != 0) && (wAddr == '0));

  always_comb begin
    rd_val0 = mem_q[rAddr0];
    if (we && (wAddr == rAddr0)) rd_val0 = wData;
    if ((ZERO_REG != 0) && (rAddr0 == '0)) rd_val0 = '0;

    rd_val1 = mem_q[rAddr1];
    if (we && (wAddr == rAddr1)) rd_val1 = wData;
    if ((ZERO_REG != 0) && (rAddr1 == '0)) rd_val1 = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
    end else if (wr_en) begin
      mem_q[wAddr] <= wData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= accept && re0;
      rvalid1_q <= accept && re1;
      if (accept && re0) rdata0_q <= rd_val0;
      if (accept && re1) rdata1_q <= rd_val1;
    end
  end

  assign rData0  = rdata0_q;
  assign rData1  = rdata1_q;
  assign rValid0 = rvalid0_q;
  assign rValid1 = rvalid1_q;
  assign busy    = (state_q == S_CLEAR);

endmodule
